// File: rtl/counter_pkg.sv
// Shared definitions for the up-counter and its sequence checker.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2,
        LOSING  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear coinciding with an increment yields 1.
module sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] count_q;
    logic [ERR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? ERR_W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_seq_checker.sv
// Tracks an observed up-counter, locks onto its sequence and flags slips and wraps.
//
// state   | meaning
// HUNT    | no reference yet; next valid sample seeds the prediction
// CONFIRM | collecting consecutive matches before declaring lock
// LOCKED  | in sequence; a mismatch is an error
// LOSING  | recent miss(es) while locked; prediction flywheels on
module count_seq_checker
    import counter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int LOCK_THRESH = 3,
    parameter int LOSS_THRESH = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_valid,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr_err,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int MC_W = $clog2(LOCK_THRESH + 1) + 1;
    localparam int MS_W = $clog2(LOSS_THRESH + 1) + 1;
    localparam logic [MC_W-1:0] LOCK_T = MC_W'(LOCK_THRESH);
    localparam logic [MS_W-1:0] LOSS_T = MS_W'(LOSS_THRESH);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [MS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             wrap_pulse_q, wrap_pulse_d;

    logic             is_match;
    logic [MC_W-1:0]  match_inc;
    logic [MS_W-1:0]  miss_inc;

    assign is_match  = (cnt_in == expected_q);
    assign match_inc = match_cnt_q + MC_W'(1);
    assign miss_inc  = miss_cnt_q + MS_W'(1);

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;

        if (cnt_valid) begin
            unique case (state_q)
                HUNT: begin
                    expected_d  = cnt_in + WIDTH'(1);
                    match_cnt_d = MC_W'(1);
                    state_d     = CONFIRM;
                end
                CONFIRM: begin
                    if (is_match) begin
                        expected_d  = expected_q + WIDTH'(1);
                        match_cnt_d = match_inc;
                        if (match_inc >= LOCK_T) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        expected_d  = cnt_in + WIDTH'(1);
                        match_cnt_d = MC_W'(1);
                    end
                end
                LOCKED, LOSING: begin
                    // Prediction always advances while locked: no resync on a miss.
                    expected_d = expected_q + WIDTH'(1);
                    if (is_match) begin
                        wrap_pulse_d = (cnt_in == '0);
                        miss_cnt_d   = '0;
                        state_d      = LOCKED;
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_cnt_d  = (state_q == LOCKED) ? MS_W'(1) : miss_inc;
                        state_d     = (miss_cnt_d >= LOSS_T) ? HUNT : LOSING;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (state_d == HUNT) begin
            match_cnt_d = '0;
            miss_cnt_d  = '0;
        end

        locked_d = (state_d == LOCKED) || (state_d == LOSING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            expected_q   <= '0;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    sat_counter #(
        .ERR_W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_pulse_d),
        .clr   (clr_err),
        .count (err_count)
    );

    assign locked     = locked_q;
    assign expected   = expected_q;
    assign err_pulse  = err_pulse_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: default instance plus a LOCK/LOSS=1 instance.
module tb_count_seq_checker;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cnt_valid = 1'b0;
    logic [3:0] cnt_in = '0;
    logic       clr_err = 1'b0;

    logic       locked, err_pulse, wrap_pulse;
    logic [3:0] expected;
    logic [7:0] err_count;
    logic       locked1, err_pulse1, wrap_pulse1;
    logic [3:0] expected1;
    logic [7:0] err_count1;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_v;

    always #5 clk = ~clk;

    count_seq_checker #(.WIDTH(4), .LOCK_THRESH(3), .LOSS_THRESH(2), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clr_err(clr_err),
        .locked(locked), .expected(expected), .err_pulse(err_pulse),
        .wrap_pulse(wrap_pulse), .err_count(err_count)
    );

    count_seq_checker #(.WIDTH(4), .LOCK_THRESH(1), .LOSS_THRESH(1), .ERR_W(8)) dut1 (
        .clk(clk), .reset(reset), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clr_err(clr_err),
        .locked(locked1), .expected(expected1), .err_pulse(err_pulse1),
        .wrap_pulse(wrap_pulse1), .err_count(err_count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] c, input logic clr);
        cnt_valid = v;
        cnt_in    = c;
        clr_err   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        // reset values
        do_reset();
        chk("rst_locked", 32'(locked), 0);
        chk("rst_expected", 32'(expected), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_wrap_pulse", 32'(wrap_pulse), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_state", 32'(dut.state_q), 32'(HUNT));

        // lock on 0,1,2,3
        step(1'b1, 4'd0, 1'b0);
        chk("lock0_locked", 32'(locked), 0);
        chk("lock0_expected", 32'(expected), 1);
        step(1'b1, 4'd1, 1'b0);
        chk("lock1_locked", 32'(locked), 0);
        step(1'b1, 4'd2, 1'b0);
        chk("lock2_locked", 32'(locked), 1);
        chk("lock2_expected", 32'(expected), 3);
        step(1'b1, 4'd3, 1'b0);
        chk("lock3_expected", 32'(expected), 4);
        chk("lock3_err_count", 32'(err_count), 0);

        // run up to 13, then wrap with 14,15,0
        for (int i = 4; i < 14; i++) step(1'b1, 4'(i), 1'b0);
        chk("pre_wrap_expected", 32'(expected), 14);
        step(1'b1, 4'd14, 1'b0);
        chk("wrap14_pulse", 32'(wrap_pulse), 0);
        step(1'b1, 4'd15, 1'b0);
        chk("wrap15_pulse", 32'(wrap_pulse), 0);
        chk("wrap15_expected", 32'(expected), 0);
        step(1'b1, 4'd0, 1'b0);
        chk("wrap0_pulse", 32'(wrap_pulse), 1);
        chk("wrap0_err_pulse", 32'(err_pulse), 0);
        chk("wrap0_expected", 32'(expected), 1);
        step(1'b1, 4'd1, 1'b0);
        chk("wrap1_pulse", 32'(wrap_pulse), 0);

        // idle cycle holds everything
        step(1'b0, 4'd9, 1'b0);
        chk("idle_expected", 32'(expected), 2);
        chk("idle_locked", 32'(locked), 1);
        chk("idle_err_pulse", 32'(err_pulse), 0);

        // single glitch at expected=5
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        step(1'b1, 4'd4, 1'b0);
        chk("glitch_pre_expected", 32'(expected), 5);
        step(1'b1, 4'd9, 1'b0);
        chk("glitch_err_pulse", 32'(err_pulse), 1);
        chk("glitch_err_count", 32'(err_count), 1);
        chk("glitch_state", 32'(dut.state_q), 32'(LOSING));
        chk("glitch_locked", 32'(locked), 1);
        chk("glitch_expected", 32'(expected), 6);
        step(1'b1, 4'd6, 1'b0);
        chk("recover_err_pulse", 32'(err_pulse), 0);
        chk("recover_state", 32'(dut.state_q), 32'(LOCKED));
        chk("recover_locked", 32'(locked), 1);
        chk("recover_err_count", 32'(err_count), 1);

        // loss of lock at expected=5
        exp_v = 4'd7;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, exp_v, 1'b0);
            exp_v = exp_v + 4'd1;
        end
        chk("loss_pre_expected", 32'(expected), 5);
        step(1'b0, 4'd0, 1'b1);
        chk("clr_err_count", 32'(err_count), 0);
        step(1'b1, 4'd9, 1'b0);
        chk("loss1_locked", 32'(locked), 1);
        step(1'b1, 4'd9, 1'b0);
        chk("loss2_err_count", 32'(err_count), 2);
        chk("loss2_locked", 32'(locked), 0);
        chk("loss2_state", 32'(dut.state_q), 32'(HUNT));
        step(1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd10, 1'b0);
        chk("relock10_locked", 32'(locked), 0);
        step(1'b1, 4'd11, 1'b0);
        chk("relock11_locked", 32'(locked), 1);
        chk("relock11_expected", 32'(expected), 12);

        // lock sequence with gaps
        do_reset();
        step(1'b1, 4'd0, 1'b0);
        step(1'b0, 4'd7, 1'b0);
        chk("gap_hold_expected", 32'(expected), 1);
        step(1'b1, 4'd1, 1'b0);
        step(1'b0, 4'd7, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        chk("gap2_locked", 32'(locked), 1);
        step(1'b0, 4'd7, 1'b0);
        step(1'b1, 4'd3, 1'b0);
        chk("gap3_expected", 32'(expected), 4);
        chk("gap3_err_count", 32'(err_count), 0);

        // thresholds of 1: second match locks, first miss drops
        do_reset();
        step(1'b1, 4'd0, 1'b0);
        chk("th1_first_locked", 32'(locked1), 0);
        step(1'b1, 4'd1, 1'b0);
        chk("th1_second_locked", 32'(locked1), 1);
        chk("th3_second_locked", 32'(locked), 0);
        step(1'b1, 4'd7, 1'b0);
        chk("th1_miss_err_pulse", 32'(err_pulse1), 1);
        chk("th1_miss_locked", 32'(locked1), 0);
        chk("th1_miss_err_count", 32'(err_count1), 1);
        chk("confirm_resync_err_pulse", 32'(err_pulse), 0);
        chk("confirm_resync_err_count", 32'(err_count), 0);
        chk("confirm_resync_expected", 32'(expected), 8);

        // saturation: alternate miss/match while locked, 300 errors
        do_reset();
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        exp_v = 4'd3;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, exp_v + 4'd5, 1'b0);
            exp_v = exp_v + 4'd1;
            step(1'b1, exp_v, 1'b0);
            exp_v = exp_v + 4'd1;
            if (i == 254) chk("sat_at_255", 32'(err_count), 255);
        end
        chk("sat_err_count", 32'(err_count), 255);
        chk("sat_locked", 32'(locked), 1);
        step(1'b1, exp_v + 4'd5, 1'b1);
        exp_v = exp_v + 4'd1;
        chk("clr_with_err_count", 32'(err_count), 1);
        chk("clr_with_err_pulse", 32'(err_pulse), 1);
        chk("pre_reset_state", 32'(dut.state_q), 32'(LOSING));

        // reset in LOSING with a valid sample pending
        reset = 1'b1;
        step(1'b1, exp_v + 4'd5, 1'b1);
        reset = 1'b0;
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_expected", 32'(expected), 0);
        chk("midrst_err_pulse", 32'(err_pulse), 0);
        chk("midrst_wrap_pulse", 32'(wrap_pulse), 0);
        chk("midrst_err_count", 32'(err_count), 0);
        chk("midrst_state", 32'(dut.state_q), 32'(HUNT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter WIDTH, default 4, width of the checked count value.
REQ-002 Parameter LOCK_THRESH, default 3, consecutive in-sequence samples needed to declare lock.
REQ-003 Parameter LOSS_THRESH, default 2, consecutive out-of-sequence samples that drop lock.
REQ-004 Parameter ERR_W, default 8, width of the error counter.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cnt_valid  input  1  cnt_in holds a sample to check this cycle.
REQ-008 cnt_in  input  WIDTH  count value from the up-counter under observation.
REQ-009 clr_err  input  1  synchronous clear of err_count.
REQ-010 locked  output  1  checker is locked to the count sequence.
REQ-011 expected  output  WIDTH  next value the checker predicts.
REQ-012 err_pulse  output  1  one-cycle flag for an out-of-sequence sample while locked.
REQ-013 wrap_pulse  output  1  one-cycle flag for an in-sequence wrap from 2^WIDTH-1 to 0 while locked.
REQ-014 err_count  output  ERR_W  saturating count of err_pulse events.

Function
REQ-015 All outputs SHALL be registered; a sample accepted on edge N is reflected on the outputs after edge N (1-cycle latency).
REQ-016 When cnt_valid=0, state, expected, internal counters and err_count SHALL hold, except for clr_err; err_pulse and wrap_pulse SHALL be 0.
REQ-017 A sample "matches" when cnt_in == expected; expected arithmetic SHALL be modulo 2^WIDTH (2^WIDTH-1 + 1 = 0).
REQ-018 The FSM SHALL have the states HUNT, CONFIRM, LOCKED and LOSING; locked SHALL be 1 exactly in LOCKED and LOSING.
REQ-019 In HUNT, any valid sample SHALL set expected=cnt_in+1 and match_cnt=1, and the FSM SHALL go to CONFIRM.
REQ-020 In CONFIRM, on a match: match_cnt+1 and expected+1; the FSM SHALL enter LOCKED when match_cnt reaches LOCK_THRESH.
REQ-021 In CONFIRM, on a mismatch: resync with expected=cnt_in+1 and match_cnt=1, staying in CONFIRM, with no error counted.
REQ-022 In LOCKED, on a match: expected+1, stay in LOCKED.
REQ-023 In LOCKED, on a mismatch: err_pulse=1, err_count+1, miss_cnt=1, expected+1 (flywheel: no resync), go to LOSING.
REQ-024 In LOSING, on a match: miss_cnt=0, go to LOCKED.
REQ-025 In LOSING, on a mismatch: err_pulse=1, err_count+1, miss_cnt+1, expected+1; on reaching LOSS_THRESH, go to HUNT with locked=0 the following cycle.
REQ-026 wrap_pulse SHALL be 1 for a matching sample equal to 0 while in LOCKED or LOSING; it SHALL never coincide with err_pulse.
REQ-027 err_count SHALL saturate at all-ones and SHALL not wrap.
REQ-028 clr_err SHALL zero err_count; if an error occurs in the same cycle, err_count SHALL become 1.
REQ-029 LOCK_THRESH=1 SHALL lock on the second matching sample after HUNT; LOSS_THRESH=1 SHALL drop lock on the first mismatch.

Reset
REQ-030 reset=1 SHALL set: state=HUNT, locked=0, expected=0, err_pulse=0, wrap_pulse=0, err_count=0, match_cnt=0, miss_cnt=0.
REQ-031 reset SHALL take priority over cnt_valid and clr_err, including reset asserted in the middle of a sequence or while in LOSING.

Structure
REQ-032 Package counter_pkg SHALL hold the FSM state enum and the default WIDTH constant, shared with the up-counter.
REQ-033 The saturating error counter SHALL be a sub-module sat_counter (ports: inc, clr, count; parameter ERR_W).
REQ-034 No other sub-modules; the FSM and expected register live in count_seq_checker.

Verification
REQ-035 Lock: after reset, samples 0,1,2,3 with cnt_valid=1 -> locked=1 after the third sample; expected=4 after the fourth sample; err_count=0.
REQ-036 Wrap: while locked, samples 14,15,0 -> wrap_pulse=1 for exactly one cycle, after the 0 sample; err_pulse=0 throughout.
REQ-037 Single glitch: while locked at expected=5, samples 9,6 -> err_pulse once, err_count=1, state LOSING then LOCKED, locked stays 1.
REQ-038 Loss: while locked at expected=5, samples 9,9 -> err_count=2, then HUNT, locked=0; then samples 9,10,11 -> relock.
REQ-039 Gaps and saturation: cnt_valid toggled 1/0 during the lock sequence -> same result as REQ-035; forcing 300 errors with ERR_W=8 -> err_count=255; clr_err together with an error -> err_count=1.
REQ-040 Reset mid-run: reset asserted in LOSING with cnt_valid=1 -> all outputs at their REQ-030 values on the next cycle.
